arm_register_file: RTL and testbench
====================================

// Module: arm_register_file
// PURPOSE
//  ARM register bank for the single-cycle datapath: 15 architectural registers R0-R14 plus R15.
//  R15 is not stored; reads of R15 return the r15 input (PC+8).
//  Sits downstream of the ALU/memory writeback mux and upstream of the ALU operand and store-data paths.
//  Provides a BL link write port and a debug read port for the testbench/FPGA display.
// PARAMETERS
//  W       32  data width of each register
//  ADDR_W   4  register address width (16 architectural indices)
// PORTS
//  clk        in   1       rising-edge clock; the only clock
//  reset      in   1       synchronous, ACTIVE-LOW reset (reset==0 at posedge clears)
//  we3        in   1       writeback port write enable
//  a1         in   ADDR_W  read port 1 address (Rn)
//  a2         in   ADDR_W  read port 2 address (Rm / Rd for STR)
//  a3         in   ADDR_W  writeback destination address
//  wd3        in   W       writeback data
//  link_we    in   1       BL link write enable (targets R14)
//  link_data  in   W       link value (PC+4 from datapath)
//  r15        in   W       value returned for reads of index 15 (PC+8)
//  dbg_sel    in   ADDR_W  debug read address
//  rd1        out  W       read data port 1
//  rd2        out  W       read data port 2
//  dbg_out    out  W       debug read data
// BEHAVIOUR
//  - Storage: R0-R14, W bits each; all updates only on posedge clk.
//  - Reset: reset==0 at posedge -> R0-R14 <= 0; reset dominates we3/link_we in that cycle.
//    After reset, rd1/rd2/dbg_out read 0 for indices 0-14 and r15 for index 15.
//  - Reads are combinational (0-cycle latency) from stored state; no write-through:
//    a read of register X in the cycle X is written returns the OLD value; the new value is visible after the edge.
//  - Index 15 on any read port -> r15 input, unconditionally.
//  - we3==1, a3 in 0..14 -> R[a3] <= wd3 at posedge.
//  - we3==1, a3==15 -> no storage change (PC update is owned by the PC path); no error flag.
//  - link_we==1 -> R14 <= link_data at posedge.
//  - Simultaneous we3 (a3==14) and link_we: link port wins; R14 <= link_data.
//  - Simultaneous we3 to a3!=14 and link_we: both writes take effect in the same edge.
//  - we3==0 and link_we==0: all registers hold.
//  - X/undefined addresses are not supported; the bench drives only known values.
//  - Reset asserted mid-program: the next edge clears R0-R14 regardless of pending writes;
//    operation resumes on the first edge with reset==1.
// STRUCTURE
//  - Shared package/header: REG_LR=4'd14, REG_PC=4'd15, NUM_STORED=15.
//  - One natural sub-module: rf_write_decoder (a3, we3, link_we -> 15-bit per-register
//    write-enable vector plus data-select, encoding the link-over-writeback priority).
//  - Top: generate loop of 15 W-bit enabled registers with synchronous active-low clear,
//    plus three identical 16:1 read muxes with the index-15 -> r15 override.
// TESTING
//  1. reset=0 one edge, then reset=1; a1=0,a2=14,dbg_sel=7,r15=32'h108 -> rd1=0,rd2=0,dbg_out=0; a1=15 -> rd1=32'h108.
//  2. we3=1,a3=3,wd3=32'hDEADBEEF; same cycle a1=3 -> rd1=0 (old); after edge rd1=32'hDEADBEEF.
//  3. we3=1,a3=15,wd3=32'h1234, r15=32'h200 -> after edge a1=15 reads 32'h200; R0-R14 unchanged.
//  4. we3=1,a3=14,wd3=32'h11 and link_we=1,link_data=32'h40 -> after edge R14 reads 32'h40.
//  5. we3=1,a3=2,wd3=32'h55 and link_we=1,link_data=32'h44 -> after edge R2=32'h55, R14=32'h44.
//  6. Fill R0-R14 with 32'hA0+i; then reset=0 with we3=1,a3=5,wd3=32'hFF -> after edge all of R0-R14 read 0.

Source files
------------

// File: rtl/arm_register_file_pkg.sv
// Shared constants and types for the ARM register bank.
//   REG_LR      index of the link register written by BL
//   REG_PC      index served from the r15 input rather than from storage
//   NUM_STORED  number of physically stored registers (R0-R14)
//   wsel_e      data source selected for the link register
package arm_register_file_pkg;

  localparam logic [3:0]  REG_LR     = 4'd14;
  localparam logic [3:0]  REG_PC     = 4'd15;
  localparam int unsigned NUM_STORED = 15;

  typedef enum logic {
    SEL_WB   = 1'b0,
    SEL_LINK = 1'b1
  } wsel_e;

endpackage

// File: rtl/arm_register_file_rf_write_decoder.sv
// Write-enable decoder for the register bank.
// Turns the writeback port (we3/a3) and the BL link port (link_we) into a
// per-register enable vector and the data source for R14.
//   a3       in   writeback destination address
//   we3      in   writeback enable
//   link_we  in   BL link write enable (targets R14)
//   we_vec   out  one enable bit per stored register R0-R14
//   lr_sel   out  data source for R14 (link beats writeback)
module rf_write_decoder
  import arm_register_file_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input  logic [ADDR_W-1:0]     a3,
  input  logic                  we3,
  input  logic                  link_we,
  output logic [NUM_STORED-1:0] we_vec,
  output wsel_e                 lr_sel
);

  always_comb begin
    we_vec = '0;
    lr_sel = SEL_WB;
    // a3 == 15 matches no stored register, so PC-directed writebacks vanish here.
    for (int unsigned i = 0; i < NUM_STORED; i++) begin
      if (we3 && (a3 == ADDR_W'(i))) begin
        we_vec[i] = 1'b1;
      end
    end
    if (link_we) begin
      we_vec[REG_LR] = 1'b1;
      lr_sel         = SEL_LINK;
    end
  end

endmodule

// File: rtl/arm_register_file.sv
// ARM register bank for the single-cycle datapath.
// R0-R14 are stored; index 15 always reads the r15 input (PC+8).
// Reads are combinational from stored state (no write-through).
//   clk        in   rising-edge clock
//   reset      in   synchronous active-low clear of R0-R14
//   we3/a3/wd3 in   writeback port
//   link_we    in   BL link write (R14 <= link_data), wins over writeback to R14
//   link_data  in   link value (PC+4)
//   r15        in   value returned for reads of index 15
//   a1/a2      in   read addresses for rd1/rd2
//   dbg_sel    in   debug read address
//   rd1/rd2    out  read data
//   dbg_out    out  debug read data
module arm_register_file
  import arm_register_file_pkg::*;
#(
  parameter int unsigned W      = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we3,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [ADDR_W-1:0] a3,
  input  logic [W-1:0]      wd3,
  input  logic              link_we,
  input  logic [W-1:0]      link_data,
  input  logic [W-1:0]      r15,
  input  logic [ADDR_W-1:0] dbg_sel,
  output logic [W-1:0]      rd1,
  output logic [W-1:0]      rd2,
  output logic [W-1:0]      dbg_out
);

  logic [NUM_STORED-1:0]        we_vec;
  wsel_e                        lr_sel;
  logic [NUM_STORED-1:0][W-1:0] bank;

  rf_write_decoder #(
    .ADDR_W (ADDR_W)
  ) u_dec (
    .a3      (a3),
    .we3     (we3),
    .link_we (link_we),
    .we_vec  (we_vec),
    .lr_sel  (lr_sel)
  );

  for (genvar g = 0; g < NUM_STORED; g++) begin : g_reg
    logic [W-1:0] d;
    logic [W-1:0] q;

    if (g == int'(REG_LR)) begin : g_lr
      assign d = (lr_sel == SEL_LINK) ? link_data : wd3;
    end else begin : g_gp
      assign d = wd3;
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        q <= '0;
      end else if (we_vec[g]) begin
        q <= d;
      end
    end

    assign bank[g] = q;
  end

  // Any index without a stored register (i.e. 15) falls through to r15.
  function automatic logic [W-1:0] read_port(
    input logic [ADDR_W-1:0]        a,
    input logic [NUM_STORED-1:0][W-1:0] regs,
    input logic [W-1:0]             pc
  );
    logic [W-1:0] v;
    v = pc;
    for (int unsigned i = 0; i < NUM_STORED; i++) begin
      if (a == ADDR_W'(i)) begin
        v = regs[i];
      end
    end
    return v;
  endfunction

  always_comb begin
    rd1 = read_port(a1, bank, r15);
  end

  always_comb begin
    rd2 = read_port(a2, bank, r15);
  end

  always_comb begin
    dbg_out = read_port(dbg_sel, bank, r15);
  end

endmodule

// File: tb/tb_arm_register_file.sv
// Self-checking bench for arm_register_file: expected read values are queued
// as stimulus is applied and drained against the three read ports.
module tb_arm_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        we3;
  logic [3:0]  a1, a2, a3, dbg_sel;
  logic [31:0] wd3, link_data, r15;
  logic        link_we;
  logic [31:0] rd1, rd2, dbg_out;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          port;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m [15];

  always #5 clk = ~clk;

  arm_register_file #(
    .W      (32),
    .ADDR_W (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .we3       (we3),
    .a1        (a1),
    .a2        (a2),
    .a3        (a3),
    .wd3       (wd3),
    .link_we   (link_we),
    .link_data (link_data),
    .r15       (r15),
    .dbg_sel   (dbg_sel),
    .rd1       (rd1),
    .rd2       (rd2),
    .dbg_out   (dbg_out)
  );

  task automatic push(input int port, input logic [31:0] exp, input string name);
    exp_t e;
    e.port = port;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] model_rd(input logic [3:0] a);
    return (a == 4'd15) ? r15 : m[a];
  endfunction

  // One clock edge; the reference model takes the same edge.
  task automatic tick();
    logic [31:0] nm [15];
    nm = m;
    if (!reset) begin
      for (int i = 0; i < 15; i++) nm[i] = '0;
    end else begin
      if (we3 && a3 != 4'd15) nm[a3] = wd3;
      if (link_we) nm[14] = link_data;
    end
    @(posedge clk);
    m = nm;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; we3 = 1'b1; a3 = 4'd2; wd3 = 32'h77;
    link_we = 1'b1; link_data = 32'h99;
    tick();
    reset = 1'b1; we3 = 1'b0; link_we = 1'b0;
    a1 = 4'd0; a2 = 4'd14; dbg_sel = 4'd7; r15 = 32'h108;
    push(0, 32'h0, "reset_rd1_r0");
    push(1, 32'h0, "reset_rd2_r14");
    push(2, 32'h0, "reset_dbg_r7");
    #1;
    while (sb.size() != 0) begin
      exp_t e; logic [31:0] obs;
      e = sb.pop_front();
      obs = (e.port == 0) ? rd1 : (e.port == 1) ? rd2 : dbg_out;
      n_vec++;
      if (obs !== e.exp) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
      end
    end
    a1 = 4'd15;
    push(0, 32'h108, "reset_rd1_r15");
    for (int i = 0; i < 15; i++) begin
      dbg_sel = 4'(i);
      #1;
      push(2, 32'h0, $sformatf("reset_dbg_r%0d", i));
      while (sb.size() != 0) begin
        exp_t e; logic [31:0] obs;
        e = sb.pop_front();
        obs = (e.port == 0) ? rd1 : (e.port == 1) ? rd2 : dbg_out;
        n_vec++;
        if (obs !== e.exp) begin
          n_err++;
          $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
        end
      end
    end
  endtask

  task automatic test_no_write_through();
    we3 = 1'b1; a3 = 4'd3; wd3 = 32'hDEADBEEF; a1 = 4'd3;
    push(0, 32'h0, "wt_old_value");
    #1;
    while (sb.size() != 0) begin
      exp_t e; logic [31:0] obs;
      e = sb.pop_front();
      obs = (e.port == 0) ? rd1 : (e.port == 1) ? rd2 : dbg_out;
      n_vec++;
      if (obs !== e.exp) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
      end
    end
    tick();
    we3 = 1'b0;
    push(0, 32'hDEADBEEF, "wt_new_value");
    #1;
    while (sb.size() != 0) begin
      exp_t e; logic [31:0] obs;
      e = sb.pop_front();
      obs = (e.port == 0) ? rd1 : (e.port == 1) ? rd2 : dbg_out;
      n_vec++;
      if (obs !== e.exp) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
      end
    end
  endtask

  task automatic test_pc_write_ignored();
    we3 = 1'b1; a3 = 4'd15; wd3 = 32'h1234; r15 = 32'h200;
    tick();
    we3 = 1'b0; a1 = 4'd15;
    push(0, 32'h200, "pcw_rd1_r15");
    for (int i = 0; i < 15; i++) begin
      dbg_sel = 4'(i);
      push(2, (i == 3) ? 32'hDEADBEEF : 32'h0, $sformatf("pcw_dbg_r%0d", i));
      #1;
      while (sb.size() != 0) begin
        exp_t e; logic [31:0] obs;
        e = sb.pop_front();
        obs = (e.port == 0) ? rd1 : (e.port == 1) ? rd2 : dbg_out;
        n_vec++;
        if (obs !== e.exp) begin
          n_err++;
          $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
        end
      end
    end
  endtask

  task automatic test_link_priority();
    we3 = 1'b1; a3 = 4'd14; wd3 = 32'h11;
    link_we = 1'b1; link_data = 32'h40;
    tick();
    we3 = 1'b0; link_we = 1'b0; a2 = 4'd14;
    push(1, 32'h40, "link_wins_r14");
    #1;
    while (sb.size() != 0) begin
      exp_t e; logic [31:0] obs;
      e = sb.pop_front();
      obs = (e.port == 0) ? rd1 : (e.port == 1) ? rd2 : dbg_out;
      n_vec++;
      if (obs !== e.exp) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
      end
    end
  endtask

  task automatic test_dual_write();
    we3 = 1'b1; a3 = 4'd2; wd3 = 32'h55;
    link_we = 1'b1; link_data = 32'h44;
    tick();
    we3 = 1'b0; link_we = 1'b0; a1 = 4'd2; a2 = 4'd14; dbg_sel = 4'd3;
    push(0, 32'h55, "dual_r2");
    push(1, 32'h44, "dual_r14");
    push(2, 32'hDEADBEEF, "dual_r3_hold");
    #1;
    while (sb.size() != 0) begin
      exp_t e; logic [31:0] obs;
      e = sb.pop_front();
      obs = (e.port == 0) ? rd1 : (e.port == 1) ? rd2 : dbg_out;
      n_vec++;
      if (obs !== e.exp) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
      end
    end
  endtask

  task automatic test_reset_mid_program();
    for (int i = 0; i < 15; i++) begin
      we3 = 1'b1; a3 = 4'(i); wd3 = 32'hA0 + 32'(i);
      tick();
    end
    we3 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      dbg_sel = 4'(i);
      push(2, 32'hA0 + 32'(i), $sformatf("fill_r%0d", i));
      #1;
      while (sb.size() != 0) begin
        exp_t e; logic [31:0] obs;
        e = sb.pop_front();
        obs = (e.port == 0) ? rd1 : (e.port == 1) ? rd2 : dbg_out;
        n_vec++;
        if (obs !== e.exp) begin
          n_err++;
          $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
        end
      end
    end
    reset = 1'b0; we3 = 1'b1; a3 = 4'd5; wd3 = 32'hFF;
    link_we = 1'b1; link_data = 32'h3C;
    tick();
    reset = 1'b1; we3 = 1'b0; link_we = 1'b0;
    for (int i = 0; i < 15; i++) begin
      dbg_sel = 4'(i);
      push(2, 32'h0, $sformatf("midrst_r%0d", i));
      #1;
      while (sb.size() != 0) begin
        exp_t e; logic [31:0] obs;
        e = sb.pop_front();
        obs = (e.port == 0) ? rd1 : (e.port == 1) ? rd2 : dbg_out;
        n_vec++;
        if (obs !== e.exp) begin
          n_err++;
          $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
        end
      end
    end
    we3 = 1'b1; a3 = 4'd5; wd3 = 32'hFF;
    tick();
    we3 = 1'b0; a1 = 4'd5;
    push(0, 32'hFF, "resume_r5");
    #1;
    while (sb.size() != 0) begin
      exp_t e; logic [31:0] obs;
      e = sb.pop_front();
      obs = (e.port == 0) ? rd1 : (e.port == 1) ? rd2 : dbg_out;
      n_vec++;
      if (obs !== e.exp) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 60; c++) begin
      we3       = 1'($urandom_range(0, 1));
      a3        = 4'($urandom_range(0, 15));
      wd3       = $urandom;
      link_we   = ($urandom_range(0, 3) == 0);
      link_data = $urandom;
      r15       = $urandom;
      a1        = 4'($urandom_range(0, 15));
      a2        = 4'($urandom_range(0, 15));
      dbg_sel   = 4'($urandom_range(0, 15));
      push(0, model_rd(a1),      $sformatf("b2b%0d_rd1", c));
      push(1, model_rd(a2),      $sformatf("b2b%0d_rd2", c));
      push(2, model_rd(dbg_sel), $sformatf("b2b%0d_dbg", c));
      #1;
      while (sb.size() != 0) begin
        exp_t e; logic [31:0] obs;
        e = sb.pop_front();
        obs = (e.port == 0) ? rd1 : (e.port == 1) ? rd2 : dbg_out;
        n_vec++;
        if (obs !== e.exp) begin
          n_err++;
          $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
        end
      end
      tick();
    end
    we3 = 1'b0; link_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; we3 = 1'b0; link_we = 1'b0;
    a1 = '0; a2 = '0; a3 = '0; dbg_sel = '0;
    wd3 = '0; link_data = '0; r15 = '0;
    @(negedge clk);
    test_reset();
    test_no_write_through();
    test_pc_write_ignored();
    test_link_priority();
    test_dual_write();
    test_reset_mid_program();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
